// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory read arbiter:
// FSM state encoding and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester winner selection.
// Default: round-robin on ties (the port not granted last wins).
// Build option MEM_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic any_req
);

    // Pick the winner index; with no request the output is a don't-care,
    // so it simply echoes last_grant.
    always_comb begin
        any_req = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (req0)
            winner = PORT_FETCH;
        else if (req1)
            winner = PORT_DATA;
        else
            winner = last_grant;
`else
        if (req0 && req1)
            winner = ~last_grant;
        else if (req0)
            winner = PORT_FETCH;
        else if (req1)
            winner = PORT_DATA;
        else
            winner = last_grant;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port read arbiter in front of a registered-read SRAM.
// IDLE -> ISSUE (cs + grant) -> RESP (data captured at the closing edge),
// with back-to-back issue from RESP when a request is pending.
// Tie policy selectable with MEM_ARB_FIXED_PRIO_EN (see arb_pick2).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_cs,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    logic              r_winner;
    logic              r_last_grant;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_mem_cs;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_winner;
    logic              w_any_req;
    logic              w_accept;
    logic [ADDR_W-1:0] w_win_addr;

    arb_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .any_req    (w_any_req)
    );

    // A new request is only accepted from IDLE or, back-to-back, from RESP.
    assign w_accept   = w_any_req && ((r_state == IDLE) || (r_state == RESP));
    assign w_win_addr = (w_winner == PORT_DATA) ? addr1 : addr0;

    // Arbiter FSM with registered grant, chip-select, address and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_winner     <= PORT_FETCH;
            r_last_grant <= PORT_DATA;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_mem_cs     <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            // Pulsed outputs default low; mem_addr and rdata hold.
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_cs  <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                ISSUE: begin
                    r_state <= RESP;
                end
                RESP: begin
                    // SRAM output is valid this cycle; hand it to the winner only.
                    if (r_winner == PORT_DATA) begin
                        r_rdata1  <= mem_rdata;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= mem_rdata;
                        r_rvalid0 <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Acceptance overrides the IDLE/RESP next state above.
            if (w_accept) begin
                r_state      <= ISSUE;
                r_winner     <= w_winner;
                r_last_grant <= w_winner;
                r_mem_cs     <= 1'b1;
                r_mem_addr   <= w_win_addr;
                r_gnt0       <= (w_winner == PORT_FETCH);
                r_gnt1       <= (w_winner == PORT_DATA);
            end
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mem_cs   = r_mem_cs;
    assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single/dual request transactions,
// plus hand sequences for reset, sustained contention and reset mid-response.
// Expected tie order follows the build option MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [3:0] addr0 = 4'd0;
    logic [3:0] addr1 = 4'd0;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_cs;
    logic [7:0] rdata0, rdata1;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] a0;
        logic [3:0] a1;
        logic       first;
        logic [7:0] d_first;
        logic [7:0] d_second;
    } vec_t;

    vec_t vecs[7];

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read SRAM model: mem[i] = i ^ 8'h5A
    always @(posedge clk) begin
        if (mem_cs)
            mem_rdata <= {4'h0, mem_addr} ^ 8'h5A;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-run invariants: cs only in the grant (ISSUE) cycle, one-hot pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cs_only_in_issue", 32'(mem_cs), 32'(gnt0 | gnt1));
            check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            check("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
        end
    end

    task automatic check_all_zero(input string name);
        check(name, 32'({gnt0, gnt1, rvalid0, rvalid1, mem_cs, mem_addr, rdata0, rdata1}), 32'd0);
    endtask

    // Apply one table vector from idle and check timing, grant order and data.
    task automatic run_txn(input int idx, input vec_t v);
        int         g_cyc[2];
        int         v_cyc[2];
        int         g_cnt[2];
        int         v_cnt[2];
        logic [7:0] v_dat[2];
        logic [7:0] snap[2];
        logic [7:0] now_rd[2];
        int         fp;
        int         sp;
        snap[0] = rdata0;
        snap[1] = rdata1;
        for (int p = 0; p < 2; p++) begin
            g_cyc[p] = -1; v_cyc[p] = -1; g_cnt[p] = 0; v_cnt[p] = 0; v_dat[p] = 8'h00;
        end
        req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (gnt0) begin
                g_cnt[0]++; g_cyc[0] = c;
                check("issue_addr0", 32'(mem_addr), 32'(addr0));
                req0 = 1'b0;
            end
            if (gnt1) begin
                g_cnt[1]++; g_cyc[1] = c;
                check("issue_addr1", 32'(mem_addr), 32'(addr1));
                req1 = 1'b0;
            end
            if (rvalid0) begin v_cnt[0]++; v_cyc[0] = c; v_dat[0] = rdata0; end
            if (rvalid1) begin v_cnt[1]++; v_cyc[1] = c; v_dat[1] = rdata1; end
        end
        now_rd[0] = rdata0;
        now_rd[1] = rdata1;
        fp = int'(v.first);
        sp = 1 - fp;
        check("first_gnt_count", 32'(g_cnt[fp]), 32'd1);
        check("first_gnt_cycle", 32'(g_cyc[fp]), 32'd1);
        check("first_rvalid_count", 32'(v_cnt[fp]), 32'd1);
        check("first_rvalid_cycle", 32'(v_cyc[fp]), 32'd3);
        check("first_rdata", 32'(v_dat[fp]), 32'(v.d_first));
        check("first_rdata_held", 32'(now_rd[fp]), 32'(v.d_first));
        if (v.r0 && v.r1) begin
            check("second_gnt_count", 32'(g_cnt[sp]), 32'd1);
            check("second_gnt_cycle", 32'(g_cyc[sp]), 32'd3);
            check("second_rvalid_cycle", 32'(v_cyc[sp]), 32'd5);
            check("second_rdata", 32'(v_dat[sp]), 32'(v.d_second));
        end else begin
            check("other_no_gnt", 32'(g_cnt[sp]), 32'd0);
            check("other_no_rvalid", 32'(v_cnt[sp]), 32'd0);
            check("other_rdata_unchanged", 32'(now_rd[sp]), 32'(snap[sp]));
        end
        $display("txn %0d: req=%b%b a0=%0d a1=%0d gnt_cyc=%0d/%0d rvalid_cyc=%0d/%0d rdata0=%02h rdata1=%02h",
                 idx, v.r1, v.r0, v.a0, v.a1, g_cyc[0], g_cyc[1], v_cyc[0], v_cyc[1], now_rd[0], now_rd[1]);
    endtask

    initial begin
        int   gport[8];
        int   gcyc[8];
        int   ng;
        int   nrv;
        vec_t fin;

        // ---- reset state (asynchronous assertion) ----
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_outputs");
        $display("txn reset: outputs after async reset checked");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- sustained contention: 8 grants, one per 2 cycles ----
        ng = 0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 4'd2; addr1 = 4'd13;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (ng < 8) begin
                    gport[ng] = gnt1 ? 1 : 0;
                    gcyc[ng]  = c;
                end
                ng++;
                if (ng == 8) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (rvalid0) check("stream_rdata0", 32'(rdata0), 32'h58);
            if (rvalid1) check("stream_rdata1", 32'(rdata1), 32'h57);
        end
        check("stream_grant_count", 32'(ng), 32'd8);
        for (int k = 0; k < 8 && k < ng; k++) begin
            check("stream_grant_port", 32'(gport[k]), FIXED ? 32'd0 : 32'(k % 2));
            check("stream_grant_cycle", 32'(gcyc[k]), 32'(2 * k + 1));
            $display("txn stream %0d: port=%0d cycle=%0d", k, gport[k], gcyc[k]);
        end
        repeat (3) @(negedge clk);

        // ---- table of directed transactions (last grant was port 1) ----
        vecs[0] = '{1'b1, 1'b0, 4'd3,  4'd0,  1'b0, 8'h59, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 8'h55, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 4'd1,  4'd2,  1'b0, 8'h5B, 8'h58};
        vecs[3] = '{1'b1, 1'b1, 4'd7,  4'd8,  1'b0, 8'h5D, 8'h52};
        vecs[4] = '{1'b0, 1'b1, 4'd0,  4'd0,  1'b1, 8'h5A, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 4'd12, 4'd0,  1'b0, 8'h56, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 4'd5,  4'd6,  FIXED ? 1'b0 : 1'b1,
                    FIXED ? 8'h5F : 8'h5C, FIXED ? 8'h5C : 8'h5F};
        for (int i = 0; i < 7; i++)
            run_txn(i, vecs[i]);

        // ---- reset pulsed during RESP ----
        req0 = 1'b1; addr0 = 4'd4;
        @(negedge clk);
        check("abort_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("abort_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        nrv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rvalid0 || rvalid1) nrv++;
        end
        check("abort_no_rvalid", 32'(nrv), 32'd0);
        $display("txn abort: reset during RESP, rvalid count=%0d", nrv);

        fin = '{1'b1, 1'b0, 4'd9, 4'd0, 1'b0, 8'h53, 8'h00};
        run_txn(7, fin);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the sequences above are bounded, this only guards a stuck sim.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  read request from port 0 (fetch) / port 1 (data).
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W  request address, held stable while req high.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse: rdata valid.
REQ-009 SHALL have ports rdata0/rdata1  output  DATA_W  read data, held between responses.
REQ-010 SHALL have port mem_cs  output  1  chip select to the registered-read SRAM.
REQ-011 SHALL have port mem_addr  output  ADDR_W  SRAM address.
REQ-012 SHALL have port mem_rdata  input  DATA_W  SRAM data_out, valid the cycle after a cs cycle.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-014 IDLE: any req high -> latch winner index and its address, go ISSUE; else stay IDLE.
REQ-015 ISSUE: mem_cs=1, mem_addr=latched address, gnt of the winner=1, all other gnt=0; always go RESP.
REQ-016 RESP: mem_cs=0; at the closing edge rdata<winner> <= mem_rdata, rvalid<winner> <= 1 for the following cycle only.
REQ-017 RESP: req pending -> arbitrate and go ISSUE directly (back-to-back); else go IDLE.
REQ-018 Latency: request sampled at edge E0 -> gnt during cycle after E0 -> rvalid during cycle after E2 (3 cycles); max throughput one read per 2 cycles.
REQ-019 Requester SHALL drop or renew req in the cycle after gnt; req still high in RESP counts as a new request.
REQ-020 Simultaneous req0 and req1: grant the port not granted last (round-robin via last_grant register, updated on every acceptance).
REQ-021 Single requester: granted regardless of last_grant; no idle bubble inserted.
REQ-022 mem_cs SHALL be 0 in every state other than ISSUE; mem_addr holds its last value outside ISSUE.
REQ-023 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 SHALL be high in any cycle.
REQ-024 rdata of the non-responding port SHALL NOT change.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, gnt*=0, rvalid*=0, rdata*=0, mem_cs=0, mem_addr=0, last_grant=1 (port 0 wins first tie).
REQ-026 Reset during ISSUE/RESP SHALL abort the transaction with no rvalid; first arbitration occurs at the first edge after rst_n is released.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN defined: ties always granted to port 0, last_grant unused; undefined: round-robin per REQ-020.

Structure
REQ-028 Shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE/ISSUE/RESP) and port index constants PORT_FETCH=0, PORT_DATA=1.
REQ-029 Winner selection SHALL be a sub-module arb_pick2 (inputs req0, req1, last_grant; output winner index, any_req).

Verification
REQ-030 SRAM model mem[i]=i^8'h5A; req0 alone, addr0=3 -> gnt0 1 cycle later, mem_cs one cycle with mem_addr=3, rvalid0 with rdata0=8'h59 three cycles after request.
REQ-031 req0 and req1 same cycle after reset, addr0=1, addr1=2 -> port 0 served first (rdata0=8'h5B), port 1 issued in the RESP cycle, rdata1=8'h58 two cycles later.
REQ-032 Both ports held requesting for 8 transactions -> grants alternate 0,1,0,1...; with MEM_ARB_FIXED_PRIO_EN all go to port 0 while req0 stays high.
REQ-033 rst_n pulsed low during RESP -> no rvalid, all outputs zero within the reset cycle, next request after release completes normally.
REQ-034 req1 alone with addr1=15 -> rdata1=8'h55; rdata0 unchanged; mem_cs never high outside ISSUE (assertion over whole run).
